// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: FSM state encoding, funct3 codes
// and byte-lane helpers used by the memory access unit.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == SB) || (f3 == SH) || (f3 == SW);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) ||
               (f3 == LBU) || (f3 == LHU);
    endfunction

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic [3:0] lane_be(input logic [1:0] size,
                                           input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                               input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] off);
        return ((size == 2'b01) && off[0]) ||
               ((size == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension for RV32I loads.
// Unknown funct3 codes produce zero.
module load_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = rdata_i[{offset_i, 3'b000} +: 8];
        h      = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = '0;
        case (funct3_i)
            LB:      data_o = {{24{b[7]}}, b};
            LH:      data_o = {{16{h[15]}}, h};
            LW:      data_o = rdata_i;
            LBU:     data_o = {24'd0, b};
            LHU:     data_o = {16'd0, h};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding data-memory transaction.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_req_valid,
    input  logic            mem_we,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            mem_stall_req,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid,
    output logic            dm_req_valid,
    input  logic            dm_req_ready,
    output logic            dm_req_we,
    output logic [XLEN-1:0] dm_req_addr,
    output logic [XLEN-1:0] dm_req_wdata,
    output logic [3:0]      dm_req_be,
    input  logic            dm_rsp_valid,
    input  logic [XLEN-1:0] dm_rsp_rdata,
    output logic            misalign_err
);

    lsu_state_e      state_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            dm_valid_q;
    logic            dm_we_q;
    logic [XLEN-1:0] dm_addr_q;
    logic [XLEN-1:0] dm_wdata_q;
    logic [3:0]      dm_be_q;
    logic [XLEN-1:0] load_data_q;
    logic            load_valid_q;

    logic            legal;
    logic            mis;
    logic [1:0]      size;
    logic [XLEN-1:0] ext_data;

    assign size  = mem_funct3[1:0];
    assign legal = f3_legal(mem_we, mem_funct3);

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_q;

    assign mis = legal && misaligned(size, mem_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= (state_q == IDLE) && mem_req_valid && mis;
    end

    assign misalign_err = mis_q;
`else
    assign mis          = 1'b0;
    assign misalign_err = 1'b0;
`endif

    load_align u_align (
        .funct3_i (f3_q),
        .offset_i (off_q),
        .rdata_i  (dm_rsp_rdata),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            dm_valid_q   <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            dm_be_q      <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem_req_valid) begin
                        we_q  <= mem_we;
                        f3_q  <= mem_funct3;
                        off_q <= mem_addr[1:0];
                        if (!legal) begin
                            state_q <= DONE;
                            if (!mem_we) begin
                                load_valid_q <= 1'b1;
                                load_data_q  <= '0;
                            end
                        end else if (mis) begin
                            state_q <= DONE;
                            if (!mem_we) load_data_q <= '0;
                        end else begin
                            state_q    <= REQ;
                            dm_valid_q <= 1'b1;
                            dm_we_q    <= mem_we;
                            dm_addr_q  <= {mem_addr[XLEN-1:2], 2'b00};
                            dm_be_q    <= lane_be(size, mem_addr[1:0]);
                            dm_wdata_q <= mem_we ? lane_wdata(size, mem_wdata)
                                                 : '0;
                        end
                    end
                end
                // request fields are frozen until the memory accepts
                REQ: begin
                    if (dm_req_ready) begin
                        dm_valid_q <= 1'b0;
                        dm_we_q    <= 1'b0;
                        dm_addr_q  <= '0;
                        dm_wdata_q <= '0;
                        dm_be_q    <= '0;
                        state_q    <= we_q ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (dm_rsp_valid) begin
                        load_data_q  <= ext_data;
                        load_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

    assign mem_stall_req = rst_n & mem_req_valid & (state_q != DONE);
    assign load_data     = load_data_q;
    assign load_valid    = load_valid_q;
    assign dm_req_valid  = dm_valid_q;
    assign dm_req_we     = dm_we_q;
    assign dm_req_addr   = dm_addr_q;
    assign dm_req_wdata  = dm_wdata_q;
    assign dm_req_be     = dm_be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, corner sequences and
// random transactions checked against a behavioural model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  mem_funct3 = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_stall_req;
    logic [31:0] load_data;
    logic        load_valid;
    logic        dm_req_valid;
    logic        dm_req_ready = 1'b0;
    logic        dm_req_we;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic [3:0]  dm_req_be;
    logic        dm_rsp_valid = 1'b0;
    logic [31:0] dm_rsp_rdata = '0;
    logic        misalign_err;

    int checks = 0;
    int failures = 0;
    bit [31:0] model_ld = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req_valid (mem_req_valid),
        .mem_we        (mem_we),
        .mem_funct3    (mem_funct3),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_stall_req (mem_stall_req),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_req_we     (dm_req_we),
        .dm_req_addr   (dm_req_addr),
        .dm_req_wdata  (dm_req_wdata),
        .dm_req_be     (dm_req_be),
        .dm_rsp_valid  (dm_rsp_valid),
        .dm_rsp_rdata  (dm_rsp_rdata),
        .misalign_err  (misalign_err)
    );

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        int        rdy;
        int        rsp;
        bit        drop;
    } txn_t;

    typedef struct {
        int        stall;
        int        hs;
        int        lv;
        int        mis;
        int        unstable;
        int        after;
        bit        timeout;
        bit        rwe;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [3:0]  be;
        bit [31:0] ld;
    } res_t;

    typedef struct {
        txn_t      t;
        int        stall;
        bit        lv;
        bit [31:0] ld;
        bit        req;
        bit [3:0]  be;
        bit [31:0] wd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit m_legal(input bit we, input bit [2:0] f3);
        if (we) return f3 <= 2;
        return (f3 != 3) && (f3 < 6);
    endfunction

    function automatic bit m_mis(input txn_t t);
`ifdef LSU_MISALIGN_CHECK_EN
        int size = (t.f3 % 4 == 0) ? 1 : (t.f3 % 4 == 1) ? 2 : 4;
        if (!m_legal(t.we, t.f3)) return 0;
        return (t.addr % size) != 0;
`else
        return 0;
`endif
    endfunction

    function automatic bit [31:0] m_ldval(input txn_t t);
        bit [31:0] v;
        int        boff = t.addr % 4;
        int        hoff = (t.addr / 2) % 2;
        case (t.f3)
            3'd0: begin
                v = (t.rdata >> (8 * boff)) & 32'hFF;
                if (v >= 128) v = v - 256;
            end
            3'd4: v = (t.rdata >> (8 * boff)) & 32'hFF;
            3'd1: begin
                v = (t.rdata >> (16 * hoff)) & 32'hFFFF;
                if (v >= 32768) v = v - 65536;
            end
            3'd5: v = (t.rdata >> (16 * hoff)) & 32'hFFFF;
            3'd2: v = t.rdata;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic bit [3:0] m_be(input txn_t t);
        if (t.f3 == 0) return 4'(1 << (t.addr % 4));
        if (t.f3 == 1) return ((t.addr / 2) % 2 == 1) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic bit [31:0] m_wd(input txn_t t);
        if (t.f3 == 0) return (t.wdata & 32'hFF) * 32'h01010101;
        if (t.f3 == 1) return (t.wdata & 32'hFFFF) * 32'h00010001;
        return t.wdata;
    endfunction

    function automatic txn_t mkt(input bit we, input bit [2:0] f3,
                                 input bit [31:0] a, input bit [31:0] wd,
                                 input bit [31:0] rd, input int rdy,
                                 input int rsp);
        txn_t t;
        t.we = we; t.f3 = f3; t.addr = a; t.wdata = wd; t.rdata = rd;
        t.rdy = rdy; t.rsp = rsp; t.drop = 0;
        return t;
    endfunction

    function automatic vec_t mkv(input txn_t t, input int st, input bit lv,
                                 input bit [31:0] ld, input bit req,
                                 input bit [3:0] be, input bit [31:0] wd);
        vec_t v;
        v.t = t; v.stall = st; v.lv = lv; v.ld = ld;
        v.req = req; v.be = be; v.wd = wd;
        return v;
    endfunction

    // Drives one transaction from a negedge, acting as the memory.
    task automatic run_txn(input txn_t t, output res_t r);
        bit first = 1;
        bit wait_rsp = 0;
        bit done = 0;
        int rdy_cnt = 0;
        int rsp_cnt = 0;
        r = '{default: 0};
        mem_req_valid = 1;
        mem_we = t.we;
        mem_funct3 = t.f3;
        mem_addr = t.addr;
        mem_wdata = t.wdata;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            if (t.drop && cyc == 1) mem_req_valid = 0;
            if (wait_rsp) begin
                dm_rsp_valid = (rsp_cnt == t.rsp);
                dm_rsp_rdata = t.rdata;
                rsp_cnt++;
                if (dm_rsp_valid) wait_rsp = 0;
            end else begin
                dm_rsp_valid = ($urandom_range(3) == 0);
                dm_rsp_rdata = $urandom;
            end
            #1;
            if (mem_stall_req) r.stall++;
            if (load_valid) r.lv++;
            if (misalign_err) r.mis++;
            if (dm_req_valid) begin
                if (first) begin
                    first = 0;
                    r.rwe = dm_req_we;
                    r.addr = dm_req_addr;
                    r.wdata = dm_req_wdata;
                    r.be = dm_req_be;
                end else if (r.rwe != dm_req_we || r.addr != dm_req_addr ||
                             r.wdata != dm_req_wdata || r.be != dm_req_be) begin
                    r.unstable++;
                end
                dm_req_ready = (rdy_cnt == t.rdy);
                rdy_cnt++;
                if (dm_req_ready) begin
                    r.hs++;
                    if (!t.we) wait_rsp = 1;
                end
            end else begin
                dm_req_ready = 0;
            end
            r.ld = load_data;
            done = t.drop ? (cyc == 14) : !mem_stall_req;
            @(negedge clk);
        end
        r.timeout = !done;
        mem_req_valid = 0;
        dm_req_ready = 0;
        dm_rsp_valid = 0;
        #1;
        r.after = int'(load_valid) + int'(misalign_err);
    endtask

    task automatic check_model(input string tag, input txn_t t,
                               input res_t r);
        bit legal = m_legal(t.we, t.f3);
        bit mis = m_mis(t);
        bit issue = legal && !mis;
        int st = 1;
        if (issue) st = t.we ? 2 + t.rdy : 3 + t.rdy + t.rsp;
        if (!t.we) model_ld = issue ? m_ldval(t) : 0;
        chk({tag, "_timeout"}, 32'(r.timeout), 0);
        if (!t.drop) chk({tag, "_stall"}, r.stall, st);
        chk({tag, "_req"}, r.hs, 32'(issue));
        chk({tag, "_lv"}, r.lv, 32'(!t.we && !mis));
        chk({tag, "_mis"}, r.mis, 32'(mis));
        chk({tag, "_ld"}, load_data, model_ld);
        chk({tag, "_after"}, r.after, 0);
        if (issue) begin
            chk({tag, "_stable"}, r.unstable, 0);
            chk({tag, "_addr"}, r.addr, t.addr & 32'hFFFF_FFFC);
            chk({tag, "_we"}, 32'(r.rwe), 32'(t.we));
            if (t.we) begin
                chk({tag, "_be"}, 32'(r.be), 32'(m_be(t)));
                chk({tag, "_wdata"}, r.wdata, m_wd(t));
            end
        end
    endtask

    initial begin
        vec_t vecs[11];
        txn_t t;
        res_t r;

        vecs[0]  = mkv(mkt(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0),
                       3, 1, 32'hDEADBEEF, 1, 4'hF, 0);
        vecs[1]  = mkv(mkt(0, 3'b000, 32'h103, 0, 32'h80123456, 0, 0),
                       3, 1, 32'hFFFFFF80, 1, 4'h8, 0);
        vecs[2]  = mkv(mkt(0, 3'b100, 32'h103, 0, 32'h80123456, 0, 0),
                       3, 1, 32'h00000080, 1, 4'h8, 0);
        vecs[3]  = mkv(mkt(1, 3'b001, 32'h102, 32'h0000ABCD, 0, 4, 0),
                       6, 0, 32'h00000080, 1, 4'hC, 32'hABCDABCD);
        vecs[4]  = mkv(mkt(1, 3'b000, 32'h101, 32'h12345678, 0, 0, 0),
                       2, 0, 32'h00000080, 1, 4'h2, 32'h78787878);
        vecs[5]  = mkv(mkt(1, 3'b010, 32'h200, 32'hCAFEF00D, 0, 1, 0),
                       3, 0, 32'h00000080, 1, 4'hF, 32'hCAFEF00D);
        vecs[6]  = mkv(mkt(0, 3'b001, 32'h102, 0, 32'h80011234, 0, 1),
                       4, 1, 32'hFFFF8001, 1, 4'hC, 0);
        vecs[7]  = mkv(mkt(0, 3'b101, 32'h100, 0, 32'h1234F00D, 1, 2),
                       6, 1, 32'h0000F00D, 1, 4'h3, 0);
        vecs[8]  = mkv(mkt(0, 3'b011, 32'h104, 0, 32'h11111111, 0, 0),
                       1, 1, 32'h00000000, 0, 4'h0, 0);
        vecs[9]  = mkv(mkt(1, 3'b100, 32'h108, 32'h55, 0, 0, 0),
                       1, 0, 32'h00000000, 0, 4'h0, 0);
        vecs[10] = mkv(mkt(0, 3'b010, 32'h10C, 0, 32'h7FFF0001, 2, 3),
                       8, 1, 32'h7FFF0001, 1, 4'hF, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", {mem_stall_req, load_valid, dm_req_valid, dm_req_we,
                         dm_req_be, misalign_err}, 0);
        chk("rst_data", load_data | dm_req_addr | dm_req_wdata, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_txn(vecs[i].t, r);
            chk($sformatf("v%0d_timeout", i), 32'(r.timeout), 0);
            chk($sformatf("v%0d_stall", i), r.stall, vecs[i].stall);
            chk($sformatf("v%0d_lv", i), r.lv, 32'(vecs[i].lv));
            chk($sformatf("v%0d_ld", i), load_data, vecs[i].ld);
            chk($sformatf("v%0d_req", i), r.hs, 32'(vecs[i].req));
            chk($sformatf("v%0d_mis", i), r.mis, 0);
            if (vecs[i].req) begin
                chk($sformatf("v%0d_stable", i), r.unstable, 0);
                chk($sformatf("v%0d_addr", i), r.addr,
                    vecs[i].t.addr & 32'hFFFF_FFFC);
            end
            if (vecs[i].req && vecs[i].t.we) begin
                chk($sformatf("v%0d_be", i), 32'(r.be), 32'(vecs[i].be));
                chk($sformatf("v%0d_wdata", i), r.wdata, vecs[i].wd);
            end
            model_ld = vecs[i].ld;
        end

        // LH at an odd address
        t = mkt(0, 3'b001, 32'h101, 0, 32'hAAAA5555, 0, 0);
        run_txn(t, r);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("lh101_req", r.hs, 0);
        chk("lh101_mis", r.mis, 1);
        chk("lh101_lv", r.lv, 0);
        chk("lh101_ld", load_data, 0);
        chk("lh101_stall", r.stall, 1);
        model_ld = 0;
`else
        chk("lh101_req", r.hs, 1);
        chk("lh101_addr", r.addr, 32'h100);
        chk("lh101_lv", r.lv, 1);
        chk("lh101_ld", load_data, 32'h00005555);
        chk("lh101_mis", r.mis, 0);
        model_ld = 32'h00005555;
`endif

        // request withdrawn after the first cycle still completes
        t = mkt(0, 3'b010, 32'h300, 0, 32'h0BADF00D, 2, 1);
        t.drop = 1;
        run_txn(t, r);
        check_model("drop", t, r);

        // reset while waiting for the response
        @(negedge clk);
        mem_req_valid = 1; mem_we = 0; mem_funct3 = 3'b010;
        mem_addr = 32'h100; dm_req_ready = 1; dm_rsp_valid = 0;
        @(negedge clk);
        #1 chk("rstw_reqv", 32'(dm_req_valid), 1);
        @(negedge clk);
        rst_n = 0; mem_req_valid = 0; dm_req_ready = 0;
        #1;
        chk("rstw_stall", 32'(mem_stall_req), 0);
        chk("rstw_dmv", 32'(dm_req_valid), 0);
        @(negedge clk);
        rst_n = 1; dm_rsp_valid = 1; dm_rsp_rdata = 32'h12345678;
        @(negedge clk);
        dm_rsp_valid = 0;
        #1;
        chk("rstw_lv", 32'(load_valid), 0);
        chk("rstw_ld", load_data, 0);
        chk("rstw_stall2", 32'(mem_stall_req), 0);
        @(negedge clk);
        #1 chk("rstw_lv2", 32'(load_valid), 0);
        model_ld = 0;
        @(negedge clk);
        t = mkt(0, 3'b000, 32'h402, 0, 32'h00FE0000, 0, 0);
        run_txn(t, r);
        check_model("post_rst", t, r);

        for (int n = 0; n < 200; n++) begin
            t = mkt($urandom_range(1), 3'($urandom_range(7)), $urandom,
                    $urandom, $urandom, $urandom_range(3),
                    $urandom_range(3));
            t.drop = ($urandom_range(9) == 0);
            run_txn(t, r);
            check_model($sformatf("rnd%0d", n), t, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
